// File: rtl/dcache_miss_ctrl.sv
// Tag/valid/dirty owner for a set-associative data cache: resolves core lookups
// and sequences the single outstanding miss (victim, writeback, fill, install).
module dcache_miss_ctrl #(
  parameter int NUM_SET        = 4,
  parameter int WAYS_PER_SET   = 2,
  parameter int ADDR_W         = 16,
  parameter int OFFSET_W       = 4,
  parameter int NUM_SET_W      = $clog2(NUM_SET),
  parameter int WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
  parameter int TAG_W          = ADDR_W - OFFSET_W - NUM_SET_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      core_req_valid,
  input  logic [ADDR_W-1:0]         core_req_addr,
  input  logic                      core_req_wr,
  output logic                      core_req_ready,
  output logic                      core_rsp_valid,
  output logic                      core_rsp_hit,
  output logic [WAYS_PER_SET_W-1:0] core_rsp_way,
  output logic                      lru_victim_req,
  output logic [NUM_SET_W-1:0]      lru_victim_set,
  input  logic [WAYS_PER_SET_W-1:0] lru_victim_way,
  output logic                      lru_update_req,
  output logic [NUM_SET_W-1:0]      lru_update_set,
  output logic [WAYS_PER_SET_W-1:0] lru_update_way,
  output logic                      mem_req_valid,
  output logic                      mem_req_wr,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  output logic [NUM_SET_W-1:0]      arr_set,
  output logic [WAYS_PER_SET_W-1:0] arr_way,
  output logic                      arr_fill_en
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_VICTIM    = 3'd2;
  localparam logic [2:0] S_WB_REQ    = 3'd3;
  localparam logic [2:0] S_WB_WAIT   = 3'd4;
  localparam logic [2:0] S_FILL_REQ  = 3'd5;
  localparam logic [2:0] S_FILL_WAIT = 3'd6;
  localparam logic [2:0] S_INSTALL   = 3'd7;

  logic [2:0]                        state_q, state_d;
  logic [NUM_SET_W-1:0]              req_set_q, req_set_d;
  logic [TAG_W-1:0]                  req_tag_q, req_tag_d;
  logic                              req_wr_q, req_wr_d;
  logic [WAYS_PER_SET_W-1:0]         way_q, way_d;
  logic [NUM_SET-1:0][WAYS_PER_SET-1:0] valid_q, valid_d;
  logic [NUM_SET-1:0][WAYS_PER_SET-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]                  tag_arr_q [NUM_SET][WAYS_PER_SET];
  logic [TAG_W-1:0]                  tag_arr_d [NUM_SET][WAYS_PER_SET];

  logic                              hit, inv_found;
  logic [WAYS_PER_SET_W-1:0]         hit_way, inv_way, victim_way;
  logic                              unused_offset;

  assign unused_offset = ^core_req_addr[OFFSET_W-1:0];

  // Descending scan so the lowest matching / lowest invalid index wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS_PER_SET-1; w >= 0; w--) begin
      if (valid_q[req_set_q][w] && (tag_arr_q[req_set_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAYS_PER_SET_W'(w);
      end
      if (!valid_q[req_set_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAYS_PER_SET_W'(w);
      end
    end
  end

  assign victim_way = inv_found ? inv_way : lru_victim_way;

  always_comb begin
    state_d        = state_q;
    req_set_d      = req_set_q;
    req_tag_d      = req_tag_q;
    req_wr_d       = req_wr_q;
    way_d          = way_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_arr_d      = tag_arr_q;
    core_req_ready = 1'b0;
    core_rsp_valid = 1'b0;
    core_rsp_hit   = 1'b0;
    core_rsp_way   = '0;
    lru_victim_req = 1'b0;
    lru_victim_set = '0;
    lru_update_req = 1'b0;
    lru_update_set = '0;
    lru_update_way = '0;
    mem_req_valid  = 1'b0;
    mem_req_wr     = 1'b0;
    mem_req_addr   = '0;
    arr_set        = '0;
    arr_way        = '0;
    arr_fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        core_req_ready = 1'b1;
        if (core_req_valid) begin
          req_set_d = core_req_addr[OFFSET_W +: NUM_SET_W];
          req_tag_d = core_req_addr[ADDR_W-1 -: TAG_W];
          req_wr_d  = core_req_wr;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          core_rsp_valid = 1'b1;
          core_rsp_hit   = 1'b1;
          core_rsp_way   = hit_way;
          lru_update_req = 1'b1;
          lru_update_set = req_set_q;
          lru_update_way = hit_way;
          if (req_wr_q) dirty_d[req_set_q][hit_way] = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_VICTIM;
        end
      end
      S_VICTIM: begin
        // The LRU is only consulted when every way of the set holds a line.
        lru_victim_req = !inv_found;
        lru_victim_set = inv_found ? '0 : req_set_q;
        way_d          = victim_way;
        if (valid_q[req_set_q][victim_way] && dirty_q[req_set_q][victim_way])
          state_d = S_WB_REQ;
        else
          state_d = S_FILL_REQ;
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = {tag_arr_q[req_set_q][way_q], req_set_q, {OFFSET_W{1'b0}}};
        arr_set       = req_set_q;
        arr_way       = way_q;
        if (mem_req_ready) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        arr_set = req_set_q;
        arr_way = way_q;
        if (mem_rsp_valid) begin
          dirty_d[req_set_q][way_q] = 1'b0;
          state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag_q, req_set_q, {OFFSET_W{1'b0}}};
        arr_set       = req_set_q;
        arr_way       = way_q;
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        arr_set = req_set_q;
        arr_way = way_q;
        if (mem_rsp_valid) begin
          arr_fill_en = 1'b1;
          state_d     = S_INSTALL;
        end
      end
      S_INSTALL: begin
        tag_arr_d[req_set_q][way_q] = req_tag_q;
        valid_d[req_set_q][way_q]   = 1'b1;
        dirty_d[req_set_q][way_q]   = req_wr_q;
        lru_update_req = 1'b1;
        lru_update_set = req_set_q;
        lru_update_way = way_q;
        core_rsp_valid = 1'b1;
        core_rsp_way   = way_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_set_q <= '0;
      req_tag_q <= '0;
      req_wr_q  <= 1'b0;
      way_q     <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_set_q <= req_set_d;
      req_tag_q <= req_tag_d;
      req_wr_q  <= req_wr_d;
      way_q     <= way_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    tag_arr_q <= tag_arr_d;
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: a transaction-level cache model predicts
// each lookup's outcome and a per-cycle monitor compares the DUT against it.
module tb_dcache_miss_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        core_req_valid = 1'b0;
  logic [15:0] core_req_addr = '0;
  logic        core_req_wr = 1'b0;
  logic        core_req_ready;
  logic        core_rsp_valid;
  logic        core_rsp_hit;
  logic [0:0]  core_rsp_way;
  logic        lru_victim_req;
  logic [1:0]  lru_victim_set;
  logic [0:0]  lru_victim_way = '0;
  logic        lru_update_req;
  logic [1:0]  lru_update_set;
  logic [0:0]  lru_update_way;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [1:0]  arr_set;
  logic [0:0]  arr_way;
  logic        arr_fill_en;

  always #5 clock = ~clock;

  dcache_miss_ctrl dut (
    .clock(clock), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
    .core_req_wr(core_req_wr), .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_hit(core_rsp_hit), .core_rsp_way(core_rsp_way),
    .lru_victim_req(lru_victim_req), .lru_victim_set(lru_victim_set), .lru_victim_way(lru_victim_way),
    .lru_update_req(lru_update_req), .lru_update_set(lru_update_set), .lru_update_way(lru_update_way),
    .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .arr_set(arr_set), .arr_way(arr_way), .arr_fill_en(arr_fill_en)
  );

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
  } memreq_t;

  bit      m_valid [4][2];
  bit      m_dirty [4][2];
  int      m_tag   [4][2];
  memreq_t exp_q[$];
  bit      exp_hit;
  int      exp_way, exp_set, exp_vq, exp_fills;

  bit          in_txn = 1'b0;
  int          cyc = 0, acc_cyc = 0;
  int          vq_count = 0, fill_count = 0, wb_count = 0, rsp_count = 0;
  int          valid_cycles = 0, last_valid_cycles = 0, last_lat = 0;
  logic        last_rsp_hit = 1'b0;
  logic [0:0]  last_rsp_way = '0;
  logic [15:0] last_wb_addr = '0, last_fill_addr = '0;

  // Per-cycle monitor: checks every visible DUT action against the model's prediction.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      in_txn = 1'b0;
      exp_q.delete();
    end else begin
      checkOutput("victim_update_overlap", 32'(lru_victim_req & lru_update_req), 32'd0);
      checkOutput("core_req_ready", 32'(core_req_ready), 32'(!in_txn));
      checkOutput("lru_update_with_rsp", 32'(lru_update_req), 32'(core_rsp_valid));
      if (core_req_valid && core_req_ready) begin
        in_txn  = 1'b1;
        acc_cyc = cyc;
      end
      if (mem_req_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("mem_req_valid_unexpected", 32'(mem_req_valid), 32'd0);
        end else begin
          checkOutput("mem_req_wr", 32'(mem_req_wr), 32'(exp_q[0].wr));
          checkOutput("mem_req_addr", 32'(mem_req_addr), 32'(exp_q[0].addr));
          checkOutput("mem_arr_set", 32'(arr_set), 32'(exp_set));
          checkOutput("mem_arr_way", 32'(arr_way), 32'(exp_way));
          valid_cycles++;
          if (mem_req_ready) begin
            if (mem_req_wr) begin
              wb_count++;
              last_wb_addr = mem_req_addr;
            end else begin
              last_fill_addr = mem_req_addr;
            end
            last_valid_cycles = valid_cycles;
            valid_cycles = 0;
            void'(exp_q.pop_front());
          end
        end
      end
      if (lru_victim_req) begin
        vq_count++;
        checkOutput("lru_victim_set", 32'(lru_victim_set), 32'(exp_set));
      end
      if (arr_fill_en) begin
        fill_count++;
        checkOutput("fill_arr_set", 32'(arr_set), 32'(exp_set));
        checkOutput("fill_arr_way", 32'(arr_way), 32'(exp_way));
      end
      if (core_rsp_valid) begin
        if (!in_txn) begin
          checkOutput("core_rsp_valid_unexpected", 32'(core_rsp_valid), 32'd0);
        end else begin
          last_lat = cyc - acc_cyc + 1;
          checkOutput("rsp_hit", 32'(core_rsp_hit), 32'(exp_hit));
          checkOutput("rsp_way", 32'(core_rsp_way), 32'(exp_way));
          checkOutput("lru_update_set", 32'(lru_update_set), 32'(exp_set));
          checkOutput("lru_update_way", 32'(lru_update_way), 32'(exp_way));
          checkOutput("mem_reqs_left", 32'(exp_q.size()), 32'd0);
          checkOutput("fill_count", 32'(fill_count), 32'(exp_fills));
          checkOutput("victim_query_count", 32'(vq_count), 32'(exp_vq));
          if (exp_hit) checkOutput("hit_latency", 32'(last_lat), 32'd2);
          last_rsp_hit = core_rsp_hit;
          last_rsp_way = core_rsp_way;
          rsp_count++;
          in_txn = 1'b0;
        end
      end
    end
  end

  // One core request: predict its outcome from the model, then play memory until it responds.
  task automatic applyStimulus(input logic [15:0] addr, input bit wr, input bit lru_way,
                               input int ready_stall, input bit abort_fill);
    int set, tag, victim, stall, abort_stage, start_rsp;
    bit done, hs_pending, hs_fill;
    set = int'(addr[5:4]);
    tag = int'(addr[15:6]);
    exp_set = set;
    exp_hit = 1'b0;
    exp_way = 0;
    for (int w = 0; w < 2; w++)
      if (!exp_hit && m_valid[set][w] && m_tag[set][w] == tag) begin
        exp_hit = 1'b1;
        exp_way = w;
      end
    if (exp_hit) begin
      if (wr) m_dirty[set][exp_way] = 1'b1;
      exp_vq = 0;
      exp_fills = 0;
    end else begin
      victim = -1;
      for (int w = 0; w < 2; w++)
        if (victim < 0 && !m_valid[set][w]) victim = w;
      exp_vq = (victim < 0) ? 1 : 0;
      if (victim < 0) victim = int'(lru_way);
      if (m_valid[set][victim] && m_dirty[set][victim])
        exp_q.push_back('{1'b1, 16'((m_tag[set][victim] << 6) | (set << 4))});
      exp_q.push_back('{1'b0, addr & 16'hFFF0});
      m_tag[set][victim]   = tag;
      m_valid[set][victim] = 1'b1;
      m_dirty[set][victim] = wr;
      exp_way = victim;
      exp_fills = 1;
    end
    vq_count = 0; fill_count = 0; wb_count = 0; valid_cycles = 0;
    start_rsp = rsp_count;
    @(posedge clock); #2;
    core_req_valid = 1'b1;
    core_req_addr  = addr;
    core_req_wr    = wr;
    lru_victim_way = lru_way;
    @(posedge clock); #2;
    core_req_valid = 1'b0;
    done = 1'b0; hs_pending = 1'b0; hs_fill = 1'b0; stall = 0; abort_stage = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c > 0) begin @(posedge clock); #2; end
      mem_rsp_valid = 1'b0;
      if (abort_stage == 1) begin
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        abort_stage = 2;
      end else if (abort_stage == 2) begin
        done = 1'b1;
      end else begin
        if (hs_pending) begin
          hs_pending = 1'b0;
          if (abort_fill && hs_fill) begin
            reset = 1'b1;
            abort_stage = 1;
            for (int s = 0; s < 4; s++)
              for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
              end
          end else begin
            mem_rsp_valid = 1'b1;
          end
        end
        if (mem_req_valid && abort_stage == 0) begin
          if (stall < ready_stall) begin
            mem_req_ready = 1'b0;
            stall++;
          end else begin
            mem_req_ready = 1'b1;
          end
        end else begin
          mem_req_ready = 1'b0;
        end
        hs_pending = mem_req_valid && mem_req_ready;
        hs_fill = !mem_req_wr;
        if (hs_pending) stall = 0;
        if (core_rsp_valid) done = 1'b1;
      end
    end
    if (!done) checkOutput("txn_timeout", 32'(done), 32'd1);
    if (abort_fill) checkOutput("no_rsp_after_abort", 32'(rsp_count - start_rsp), 32'd0);
    reset = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(posedge clock); #2;
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_core_req_ready", 32'(core_req_ready), 32'd1);
    checkOutput("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset_mem_req_addr", 32'(mem_req_addr), 32'd0);
    checkOutput("reset_core_rsp_valid", 32'(core_rsp_valid), 32'd0);
    checkOutput("reset_arr_fill_en", 32'(arr_fill_en), 32'd0);
    checkOutput("reset_lru_reqs", 32'({lru_victim_req, lru_update_req}), 32'd0);

    applyStimulus(16'h1230, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t1_fill_addr", 32'(last_fill_addr), 32'h1230);
    checkOutput("t1_rsp_hit", 32'(last_rsp_hit), 32'd0);
    checkOutput("t1_rsp_way", 32'(last_rsp_way), 32'd0);
    checkOutput("t1_no_wb", 32'(wb_count), 32'd0);

    applyStimulus(16'h1230, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t2_rsp_hit", 32'(last_rsp_hit), 32'd1);
    checkOutput("t2_latency", 32'(last_lat), 32'd2);

    applyStimulus(16'h2230, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("t3_rsp_way", 32'(last_rsp_way), 32'd1);
    checkOutput("t3_no_query", 32'(vq_count), 32'd0);

    applyStimulus(16'h3230, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t4_query", 32'(vq_count), 32'd1);
    checkOutput("t4_fill_addr", 32'(last_fill_addr), 32'h3230);
    checkOutput("t4_no_wb", 32'(wb_count), 32'd0);
    checkOutput("t4_rsp_way", 32'(last_rsp_way), 32'd0);

    applyStimulus(16'h2230, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("t5_store_hit_way", 32'({last_rsp_hit, last_rsp_way}), 32'd3);

    applyStimulus(16'h4230, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("t6_wb_count", 32'(wb_count), 32'd1);
    checkOutput("t6_wb_addr", 32'(last_wb_addr), 32'h2230);
    checkOutput("t6_fill_addr", 32'(last_fill_addr), 32'h4230);
    checkOutput("t6_rsp_way", 32'(last_rsp_way), 32'd1);

    applyStimulus(16'h4230, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t7_hit_way1", 32'({last_rsp_hit, last_rsp_way}), 32'd3);

    applyStimulus(16'h5230, 1'b0, 1'b1, 5, 1'b0);
    checkOutput("t8_clean_no_wb", 32'(wb_count), 32'd0);
    checkOutput("t8_valid_cycles", 32'(last_valid_cycles), 32'd6);
    checkOutput("t8_fill_addr", 32'(last_fill_addr), 32'h5230);

    @(posedge clock); #2;
    mem_rsp_valid = 1'b1;
    mem_req_ready = 1'b1;
    @(posedge clock); #2;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    applyStimulus(16'h5230, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t9_hit_after_spurious", 32'({last_rsp_hit, last_rsp_way}), 32'd3);

    applyStimulus(16'h0010, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(16'h0410, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t10_fill_way1", 32'(last_rsp_way), 32'd1);
    checkOutput("t10_no_query", 32'(vq_count), 32'd0);

    applyStimulus(16'h6230, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clock);
    checkOutput("t11_ready_after_abort", 32'(core_req_ready), 32'd1);

    applyStimulus(16'h1230, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("t12_miss_after_reset", 32'(last_rsp_hit), 32'd0);
    checkOutput("t12_rsp_way", 32'(last_rsp_way), 32'd0);
    checkOutput("t12_no_query", 32'(vq_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
